// File: rtl/serial_add_sub.sv
// serial_add_sub: bit-serial adder/subtractor, LSB first, one bit per clock.
// Subtraction is done as A + ~B + 1, so the carry-in is seeded with ctrl and
// B is inverted on capture. cb is the raw carry-out (for subtract: 1 = no borrow).
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | waiting for operands, in_ready=1
// RUN    | one full-add per cycle, WIDTH cycles total
// DONE   | result presented on sd/cb with out_valid=1 until accepted
module serial_add_sub #(
    parameter int WIDTH = 4,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ctrl,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sd,
    output logic             cb,
    output logic             busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] opa_q;
    logic [WIDTH-1:0] opb_q;
    logic [WIDTH-1:0] res_q;
    logic             carry_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] sd_q;
    logic             cb_q;

    logic             sum_bit;
    logic             carry_nxt;
    logic             last_bit;
    logic             in_fire;
    logic             out_fire;

    assign sum_bit   = opa_q[0] ^ opb_q[0] ^ carry_q;
    assign carry_nxt = (opa_q[0] & opb_q[0]) | (carry_q & (opa_q[0] ^ opb_q[0]));
    assign last_bit  = (cnt_q == LAST_CNT);
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;
    assign sd        = sd_q;
    assign cb        = cb_q;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (in_fire) state_d = S_RUN;
            S_RUN:   if (last_bit) state_d = S_DONE;
            S_DONE:  if (out_fire) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Handshake and status outputs decoded from the current state.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state_q)
            S_IDLE: in_ready = 1'b1;
            S_RUN:  busy = 1'b1;
            S_DONE: begin
                out_valid = 1'b1;
                busy      = 1'b1;
            end
            default: in_ready = 1'b0;
        endcase
    end

    // Serial datapath: capture operands, shift one bit per RUN cycle, load result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            opa_q   <= '0;
            opb_q   <= '0;
            res_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            sd_q    <= '0;
            cb_q    <= 1'b0;
        end else if (in_fire) begin
            opa_q   <= a;
            opb_q   <= b ^ {WIDTH{ctrl}};
            res_q   <= '0;
            carry_q <= ctrl;
            cnt_q   <= '0;
        end else if (state_q == S_RUN) begin
            opa_q   <= opa_q >> 1;
            opb_q   <= opb_q >> 1;
            res_q   <= {sum_bit, res_q[WIDTH-1:1]};
            carry_q <= carry_nxt;
            cnt_q   <= cnt_q + CNT_W'(1);
            if (last_bit) begin
                sd_q <= {sum_bit, res_q[WIDTH-1:1]};
                cb_q <= carry_nxt;
            end
        end
    end

endmodule

// File: tb/tb_serial_add_sub.sv
// Directed bench for serial_add_sub at WIDTH=4.
module tb_serial_add_sub;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] a;
    logic [3:0] b;
    logic       ctrl;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] sd;
    logic       cb;
    logic       busy;

    int n_tests;
    int n_fail;

    serial_add_sub #(.WIDTH(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .ctrl      (ctrl),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sd        (sd),
        .cb        (cb),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one operation and collect the result; comparisons are left to the caller.
    task automatic run_op(input logic [3:0] ta, input logic [3:0] tb_v, input logic tc,
                          input int stall, output logic [3:0] rsd, output logic rcb,
                          output int lat, output logic done_ok, output logic hold_ok);
        int g;
        done_ok = 1'b1;
        hold_ok = 1'b1;
        lat     = 0;
        g       = 0;
        a        = ta;
        b        = tb_v;
        ctrl     = tc;
        in_valid = 1'b1;
        out_ready = (stall == 0);
        while (!in_ready && g < 20) begin
            @(posedge clk); #1;
            g++;
        end
        if (!in_ready) done_ok = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        a        = ~ta;
        b        = ~tb_v;
        ctrl     = ~tc;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!out_valid) done_ok = 1'b0;
        rsd = sd;
        rcb = cb;
        for (int i = 0; i < stall; i++) begin
            @(posedge clk); #1;
            if (!out_valid || sd !== rsd || cb !== rcb || in_ready) hold_ok = 1'b0;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        if (out_valid || !in_ready) done_ok = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = 4'h0; b = 4'h0; ctrl = 1'b0;
        #12;
        n_tests++;
        if ({in_ready, out_valid, busy, sd, cb} !== {1'b1, 1'b0, 1'b0, 4'h0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_state: got rdy=%b vld=%b busy=%b sd=%b cb=%b, want 1 0 0 0000 0",
                     in_ready, out_valid, busy, sd, cb);
        end
        #11 rst_n = 1'b1;
        @(posedge clk); #1;
        n_tests++;
        if (in_ready !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release_idle: got rdy=%b busy=%b, want 1 0", in_ready, busy);
        end
    endtask

    task automatic test_add();
        logic [3:0] r; logic c; int l; logic ok; logic h;
        run_op(4'b1101, 4'b1010, 1'b0, 1, r, c, l, ok, h);
        n_tests++;
        if (!ok || r !== 4'b0111 || c !== 1'b1 || l != 4) begin
            n_fail++;
            $display("FAIL add_1101_1010: got sd=%b cb=%b lat=%0d ok=%b, want 0111 1 4 1", r, c, l, ok);
        end
    endtask

    task automatic test_sub();
        logic [3:0] r; logic c; int l; logic ok; logic h;
        run_op(4'b1101, 4'b1010, 1'b1, 0, r, c, l, ok, h);
        n_tests++;
        if (!ok || r !== 4'b0011 || c !== 1'b1 || l != 4) begin
            n_fail++;
            $display("FAIL sub_1101_1010: got sd=%b cb=%b lat=%0d ok=%b, want 0011 1 4 1", r, c, l, ok);
        end
        run_op(4'b0011, 4'b0101, 1'b1, 2, r, c, l, ok, h);
        n_tests++;
        if (!ok || !h || r !== 4'b1110 || c !== 1'b0 || l != 4) begin
            n_fail++;
            $display("FAIL sub_0011_0101: got sd=%b cb=%b lat=%0d ok=%b hold=%b, want 1110 0 4 1 1",
                     r, c, l, ok, h);
        end
    endtask

    task automatic test_back_pressure();
        int l;
        a = 4'b0110; b = 4'b0111; ctrl = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        // Keep offering different operands while busy; they must be ignored.
        a = 4'b1111; b = 4'b1111; ctrl = 1'b1;
        n_tests++;
        if (busy !== 1'b1 || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_run_status: got busy=%b rdy=%b, want 1 0", busy, in_ready);
        end
        l = 0;
        while (!out_valid && l < 20) begin
            @(posedge clk); #1;
            l++;
        end
        n_tests++;
        if (l != 4 || out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_latency: got lat=%0d vld=%b, want 4 1", l, out_valid);
        end
        for (int i = 0; i < 10; i++) begin
            n_tests++;
            if (out_valid !== 1'b1 || sd !== 4'b1101 || cb !== 1'b0 || in_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL bp_hold_%0d: got vld=%b sd=%b cb=%b rdy=%b, want 1 1101 0 0",
                         i, out_valid, sd, cb, in_ready);
            end
            @(posedge clk); #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        n_tests++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_release: got rdy=%b vld=%b busy=%b, want 1 0 0", in_ready, out_valid, busy);
        end
    endtask

    task automatic test_boundary();
        logic [3:0] r; logic c; int l; logic ok; logic h;
        run_op(4'b1111, 4'b0001, 1'b0, 0, r, c, l, ok, h);
        n_tests++;
        if (!ok || r !== 4'b0000 || c !== 1'b1) begin
            n_fail++;
            $display("FAIL bnd_1111_plus_0001: got sd=%b cb=%b ok=%b, want 0000 1 1", r, c, ok);
        end
        run_op(4'b0000, 4'b0000, 1'b1, 1, r, c, l, ok, h);
        n_tests++;
        if (!ok || r !== 4'b0000 || c !== 1'b1) begin
            n_fail++;
            $display("FAIL bnd_0_minus_0: got sd=%b cb=%b ok=%b, want 0000 1 1", r, c, ok);
        end
        run_op(4'b1111, 4'b1111, 1'b0, 0, r, c, l, ok, h);
        n_tests++;
        if (!ok || r !== 4'b1110 || c !== 1'b1) begin
            n_fail++;
            $display("FAIL bnd_max_plus_max: got sd=%b cb=%b ok=%b, want 1110 1 1", r, c, ok);
        end
    endtask

    task automatic test_reset_mid();
        logic [3:0] r; logic c; int l; logic ok; logic h;
        run_op(4'b0110, 4'b0111, 1'b0, 0, r, c, l, ok, h);
        a = 4'b1001; b = 4'b0010; ctrl = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        n_tests++;
        if ({in_ready, out_valid, busy, sd, cb} !== {1'b1, 1'b0, 1'b0, 4'h0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_mid: got rdy=%b vld=%b busy=%b sd=%b cb=%b, want 1 0 0 0000 0",
                     in_ready, out_valid, busy, sd, cb);
        end
        #3 rst_n = 1'b1;
        @(posedge clk); #1;
        run_op(4'b0101, 4'b0011, 1'b0, 0, r, c, l, ok, h);
        n_tests++;
        if (!ok || r !== 4'b1000 || c !== 1'b0 || l != 4) begin
            n_fail++;
            $display("FAIL after_reset_add: got sd=%b cb=%b lat=%0d ok=%b, want 1000 0 4 1", r, c, l, ok);
        end
    endtask

    task automatic test_sweep();
        logic [3:0] r; logic c; int l; logic ok; logic h;
        int exp_v; logic [3:0] exp_sd; logic exp_cb;
        for (int op = 0; op < 2; op++) begin
            for (int x = 0; x < 16; x++) begin
                for (int y = 0; y < 16; y++) begin
                    run_op(x[3:0], y[3:0], op[0], int'($urandom_range(0, 3)), r, c, l, ok, h);
                    if (op == 0) begin
                        exp_v  = x + y;
                        exp_cb = (exp_v > 15);
                    end else begin
                        exp_v  = x - y + 16;
                        exp_cb = (x >= y);
                    end
                    exp_sd = exp_v[3:0];
                    n_tests++;
                    if (!ok || !h || l != 4 || r !== exp_sd || c !== exp_cb) begin
                        n_fail++;
                        $display("FAIL sweep op=%0d a=%0d b=%0d: got sd=%b cb=%b lat=%0d ok=%b hold=%b, want %b %b 4 1 1",
                                 op, x, y, r, c, l, ok, h, exp_sd, exp_cb);
                    end
                end
            end
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        test_reset();
        test_add();
        test_sub();
        test_back_pressure();
        test_boundary();
        test_reset_mid();
        test_sweep();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
